// File: rtl/bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_master_pkg
// Brief   : Shared types and widths for the bus_master_seq initiator.
// Rev     : 1.0  initial release
// ============================================================================
package bus_master_pkg;

    localparam int LAT_W = 4;
    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bm_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_bus.sv
`default_nettype none
// ============================================================================
// Module  : bus_slave (interface)
// Brief   : Simple strobe-based peripheral bus; 'out' faces the initiator,
//           'in' faces the peripheral.
// Rev     : 1.0  initial release
// ============================================================================
interface bus_slave;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport out (output wr, output rd, output addr, output data_i, input data_o);
    modport in  (input wr, input rd, input addr, input data_i, output data_o);
endinterface
`default_nettype wire

// File: rtl/bus_master_seq.sv
`default_nettype none
// ============================================================================
// Module  : bus_master_seq
// Brief   : Single-command bus initiator: valid/ready command in, one-cycle
//           wr/rd strobe out, fixed-latency read sampling, valid/ready read
//           response. Optional read bursts with BUS_MASTER_RD_BURST_EN.
// Rev     : 1.0  initial release
// ============================================================================
module bus_master_seq
    import bus_master_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
`ifdef BUS_MASTER_RD_BURST_EN
    input  logic [LEN_W-1:0] cmd_len,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    bus_slave.out            bus
);

    generate
        if (RD_LATENCY < 0 || RD_LATENCY > 15) begin : g_lat_range_err
            $error("bus_master_seq: RD_LATENCY must be within 0..15");
        end
    endgenerate

    localparam logic [LAT_W-1:0] c_lat  = LAT_W'(RD_LATENCY);
    localparam logic [31:0]      c_step = 32'(ADDR_STEP);

    bm_state_t         r_state;
    bm_state_t         w_state_nxt;
    logic              r_wr;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [LAT_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_in;
    logic              w_accept;
    logic              w_sample;
    logic              w_rsp_hs;
    logic              w_more;

    // Beats remaining after the current one; forced to zero without bursts.
`ifdef BUS_MASTER_RD_BURST_EN
    assign w_len_in = cmd_wr ? '0 : cmd_len;
`else
    assign w_len_in = '0;
`endif

    assign w_accept = (r_state == IDLE) && cmd_valid;
    assign w_rsp_hs = (r_state == RESP) && rsp_ready;
    assign w_more   = (r_len != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (r_wr) begin
                    w_state_nxt = IDLE;
                end else if (c_lat == '0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == LAT_W'(1)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) w_state_nxt = w_more ? ISSUE : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wr    <= cmd_wr;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_len   <= w_len_in;
            end
            if (r_state == ISSUE) begin
                r_cnt <= c_lat;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - LAT_W'(1);
            end
            if (w_sample) r_rdata <= bus.data_o;
            // Next burst beat: address wraps naturally at 2^32.
            if (w_rsp_hs && w_more) begin
                r_len  <= r_len - LEN_W'(1);
                r_addr <= r_addr + c_step;
            end
        end
    end

    assign cmd_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign rsp_rdata  = r_rdata;
    assign bus.wr     = (r_state == ISSUE) &&  r_wr;
    assign bus.rd     = (r_state == ISSUE) && !r_wr;
    assign bus.addr   = r_addr;
    assign bus.data_i = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_master_seq
// Brief   : Self-checking bench; three initiators with read latency 0, 1, 3.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bus_master_seq;

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rsp_off;
        logic [31:0] rdata;
    } vec_t;

    typedef struct { bit wr; logic [31:0] a; logic [31:0] d; int c; } ev_t;
    typedef struct { logic [31:0] d; int c; } rs_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       cv, cwr, rr;
    logic [2:0][31:0] caddr, cwd;
    logic [2:0]       cr, rv, bwr, brd;
    logic [2:0][31:0] rdat, baddr, bdi;
`ifdef BUS_MASTER_RD_BURST_EN
    logic [2:0][7:0]  cl;
`endif

    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   viol = 0;
    int   act = 0;
    bit   mon_en = 1'b0;
    bit   acc_seen = 1'b0;
    bit   rv_prev = 1'b0;
    ev_t  bq[$];
    rs_t  rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        if (a == 32'h20) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", nm, got, exp);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        bus_slave u_bus();

        bus_master_seq #(.RD_LATENCY(L), .ADDR_STEP(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cv[g]),
            .cmd_ready (cr[g]),
            .cmd_wr    (cwr[g]),
            .cmd_addr  (caddr[g]),
            .cmd_wdata (cwd[g]),
`ifdef BUS_MASTER_RD_BURST_EN
            .cmd_len   (cl[g]),
`endif
            .rsp_valid (rv[g]),
            .rsp_ready (rr[g]),
            .rsp_rdata (rdat[g]),
            .bus       (u_bus)
        );

        assign bwr[g]   = u_bus.wr;
        assign brd[g]   = u_bus.rd;
        assign baddr[g] = u_bus.addr;
        assign bdi[g]   = u_bus.data_i;

        // Slave model: data valid exactly L cycles after the rd strobe, junk otherwise.
        if (L == 0) begin : g_comb
            assign u_bus.data_o = u_bus.rd ? slv_data(u_bus.addr) : (32'hBAD0_0000 ^ 32'(cyc));
        end else begin : g_pipe
            logic [L-1:0] r_v;
            logic [31:0]  r_a [L];
            always @(posedge clk) begin
                r_v[0] <= u_bus.rd;
                r_a[0] <= u_bus.addr;
                for (int i = 1; i < L; i++) begin
                    r_v[i] <= r_v[i-1];
                    r_a[i] <= r_a[i-1];
                end
            end
            assign u_bus.data_o = r_v[L-1] ? slv_data(r_a[L-1]) : (32'hBAD0_0000 ^ 32'(cyc));
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) if (bwr[k] && brd[k]) viol++;
    end

    // Scoreboard for the randomized phase on instance 'act'.
    always @(negedge clk) begin
        ev_t e;
        int  k;
        k = act;
        if (mon_en) begin
            if (cv[k] && cr[k]) begin
                bq.push_back('{cwr[k], caddr[k], cwd[k], cyc});
                if (!cwr[k]) rq.push_back('{slv_data(caddr[k]), cyc});
                acc_seen = 1'b1;
            end else begin
                acc_seen = 1'b0;
            end
            if (bwr[k] || brd[k]) begin
                if (bq.size() == 0) begin
                    chk("rnd_spurious_strobe", 1, 0);
                end else begin
                    e = bq.pop_front();
                    chk("rnd_strobe_kind", 32'(bwr[k]), 32'(e.wr));
                    chk("rnd_strobe_addr", baddr[k], e.a);
                    if (e.wr) chk("rnd_strobe_wdata", bdi[k], e.d);
                    chk("rnd_strobe_cycle", cyc - e.c, 1);
                end
            end
            if (rv[k] && !rv_prev) begin
                if (rq.size() == 0) begin
                    chk("rnd_spurious_rsp", 1, 0);
                end else begin
                    chk("rnd_rsp_cycle", cyc - rq[0].c, 2 + lat_of(k));
                    chk("rnd_rsp_data_first", rdat[k], rq[0].d);
                end
            end
            if (rv[k] && rr[k] && rq.size() != 0) begin
                chk("rnd_rsp_data_hs", rdat[k], rq[0].d);
                void'(rq.pop_front());
            end
            rv_prev = rv[k];
        end
    end

    task automatic do_txn(input int idx, input vec_t v);
        int t_acc = -1, t_stb = -1, t_rsp = -1, n_stb = 0, n_rv = 0;
        bit w_stb = 1'b0, cr1 = 1'b1, cr2 = 1'b0;
        logic [31:0] a_stb = '0, d_stb = '0, r_d = '0;
        @(posedge clk); #1;
        cv[v.k] = 1'b1; cwr[v.k] = v.wr; caddr[v.k] = v.addr; cwd[v.k] = v.wdata; rr[v.k] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (t_acc < 0 && cv[v.k] && cr[v.k]) t_acc = t;
            if (bwr[v.k] || brd[v.k]) begin
                n_stb++;
                if (t_stb < 0) begin
                    t_stb = t; w_stb = bwr[v.k]; a_stb = baddr[v.k]; d_stb = bdi[v.k];
                end
            end
            if (rv[v.k]) begin
                n_rv++;
                if (t_rsp < 0) begin t_rsp = t; r_d = rdat[v.k]; end
            end
            if (t_acc >= 0 && t == t_acc + 1) cr1 = cr[v.k];
            if (t_acc >= 0 && t == t_acc + 2) cr2 = cr[v.k];
            @(posedge clk); #1;
            if (t_acc >= 0) cv[v.k] = 1'b0;
        end
        chk($sformatf("vec%0d_accept", idx), t_acc, 0);
        chk($sformatf("vec%0d_strobe_off", idx), t_stb - t_acc, 1);
        chk($sformatf("vec%0d_strobe_count", idx), n_stb, 1);
        chk($sformatf("vec%0d_strobe_wr", idx), 32'(w_stb), 32'(v.wr));
        chk($sformatf("vec%0d_addr", idx), a_stb, v.addr);
        if (v.wr) begin
            chk($sformatf("vec%0d_data_i", idx), d_stb, v.wdata);
            chk($sformatf("vec%0d_no_rsp", idx), n_rv, 0);
            chk($sformatf("vec%0d_ready_t1", idx), 32'(cr1), 0);
            chk($sformatf("vec%0d_ready_t2", idx), 32'(cr2), 1);
        end else begin
            chk($sformatf("vec%0d_rsp_off", idx), t_rsp - t_acc, v.rsp_off);
            chk($sformatf("vec%0d_rsp_cycles", idx), n_rv, 1);
            chk($sformatf("vec%0d_rdata", idx), r_d, v.rdata);
        end
    endtask

    task automatic stall_seq();
        int bad_v = 0, bad_d = 0, n_stb = 0, bad_r = 0, dup = 0;
        logic [31:0] d0;
        @(posedge clk); #1;
        cv[1] = 1'b1; cwr[1] = 1'b0; caddr[1] = 32'h100; cwd[1] = '0; rr[1] = 1'b0;
        @(negedge clk);
        chk("stall_accept", 32'(cr[1]), 1);
        @(posedge clk); #1;
        cwr[1] = 1'b1; caddr[1] = 32'h200; cwd[1] = 32'hCAFE_F00D;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rv[1]) break;
        end
        chk("stall_rsp_seen", 32'(rv[1]), 1);
        d0 = rdat[1];
        chk("stall_rdata", d0, slv_data(32'h100));
        repeat (5) begin
            @(negedge clk);
            if (!rv[1]) bad_v++;
            if (rdat[1] !== d0) bad_d++;
            if (bwr[1] || brd[1]) n_stb++;
            if (cr[1]) bad_r++;
        end
        chk("stall_valid_held", bad_v, 0);
        chk("stall_rdata_stable", bad_d, 0);
        chk("stall_no_strobe", n_stb, 0);
        chk("stall_ready_low", bad_r, 0);
        @(posedge clk); #1; rr[1] = 1'b1;
        @(negedge clk);
        chk("stall_ready_at_hs", 32'(cr[1]), 0);
        @(negedge clk);
        chk("stall_ready_after_hs", 32'(cr[1]), 1);
        chk("stall_valid_drop", 32'(rv[1]), 0);
        @(posedge clk); #1; cv[1] = 1'b0;
        @(negedge clk);
        chk("stall_next_wr", 32'(bwr[1]), 1);
        chk("stall_next_addr", baddr[1], 32'h200);
        chk("stall_next_data", bdi[1], 32'hCAFE_F00D);
        repeat (5) begin
            @(negedge clk);
            if (bwr[1] || brd[1]) dup++;
        end
        chk("stall_no_dup", dup, 0);
    endtask

    task automatic reset_seq();
        int late = 0;
        vec_t v;
        @(posedge clk); #1;
        cv[2] = 1'b1; cwr[2] = 1'b0; caddr[2] = 32'h300; rr[2] = 1'b1;
        @(negedge clk);
        chk("rstw_accept", 32'(cr[2]), 1);
        @(posedge clk); #1; cv[2] = 1'b0;
        @(negedge clk);
        chk("rstw_strobe", 32'(brd[2]), 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rstw_rsp_valid", 32'(rv[2]), 0);
        chk("rstw_rd", 32'(brd[2]), 0);
        chk("rstw_ready", 32'(cr[2]), 1);
        repeat (8) begin
            @(negedge clk);
            if (rv[2] || brd[2]) late++;
        end
        chk("rstw_no_late_rsp", late, 0);
        v = '{2, 1'b0, 32'h300, 32'h0, 5, slv_data(32'h300)};
        do_txn(100, v);
    endtask

`ifdef BUS_MASTER_RD_BURST_EN
    task automatic burst_seq();
        logic [31:0] aq[$];
        int nrsp = 0, t_acc = -1, t_last = -1, bad_cr = 0;
        bit cr_after = 1'b0;
        @(posedge clk); #1;
        cv[1] = 1'b1; cwr[1] = 1'b0; caddr[1] = 32'hFFFF_FFF8; cl[1] = 8'd2; rr[1] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (t_acc < 0 && cv[1] && cr[1]) t_acc = t;
            else if (t_acc >= 0 && t_last < 0 && cr[1]) bad_cr++;
            if (brd[1]) aq.push_back(baddr[1]);
            if (t_last >= 0 && t == t_last + 1) cr_after = cr[1];
            if (rv[1] && rr[1]) begin
                chk("burst_rdata", rdat[1], slv_data(32'hFFFF_FFF8 + 32'(4 * nrsp)));
                nrsp++;
                if (nrsp == 3) t_last = t;
            end
            @(posedge clk); #1;
            if (t_acc >= 0) begin cv[1] = 1'b0; cl[1] = '0; end
        end
        chk("burst_strobes", aq.size(), 3);
        if (aq.size() == 3) begin
            chk("burst_addr0", aq[0], 32'hFFFF_FFF8);
            chk("burst_addr1", aq[1], 32'hFFFF_FFFC);
            chk("burst_addr2", aq[2], 32'h0000_0000);
        end
        chk("burst_rsp_count", nrsp, 3);
        chk("burst_ready_low", bad_cr, 0);
        chk("burst_ready_back", 32'(cr_after), 1);
    endtask
`endif

    task automatic run_random(input int k, input int n);
        int issued = 0;
        int guard = 0;
        act = k; bq.delete(); rq.delete(); rv_prev = 1'b0; acc_seen = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        while ((issued < n || cv[k] || bq.size() != 0 || rq.size() != 0) && guard < 4000) begin
            @(posedge clk); #1;
            guard++;
            if (acc_seen) cv[k] = 1'b0;
            if (!cv[k] && issued < n && $urandom_range(0, 3) != 0) begin
                cwr[k]   = 1'($urandom_range(0, 1));
                caddr[k] = $urandom & 32'hFFFF_FFFC;
                cwd[k]   = $urandom;
                cv[k]    = 1'b1;
                issued++;
            end
            rr[k] = ($urandom_range(0, 3) != 0);
        end
        chk($sformatf("rnd%0d_drained", k), 32'(guard < 4000), 1);
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b0;
        rr[k] = 1'b1;
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, -1, 32'h0};
        tbl[1] = '{1, 1'b0, 32'h0000_0020, 32'h0,         3,  32'h1234_5678};
        tbl[2] = '{0, 1'b0, 32'h0000_0040, 32'h0,         2,  slv_data(32'h40)};
        tbl[3] = '{2, 1'b0, 32'h0000_0080, 32'h0,         5,  slv_data(32'h80)};
        tbl[4] = '{0, 1'b1, 32'h0000_0044, 32'h0102_0304, -1, 32'h0};
        tbl[5] = '{2, 1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, -1, 32'h0};
        tbl[6] = '{2, 1'b0, 32'h0000_0020, 32'h0,         5,  32'h1234_5678};
        tbl[7] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         2,  slv_data(32'hFFFF_FFFC)};

        rst = 1'b1; cv = '0; cwr = '0; caddr = '0; cwd = '0; rr = '0;
`ifdef BUS_MASTER_RD_BURST_EN
        cl = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_cmd_ready", k), 32'(cr[k]), 1);
            chk($sformatf("rst%0d_rsp_valid", k), 32'(rv[k]), 0);
            chk($sformatf("rst%0d_rsp_rdata", k), rdat[k], 0);
            chk($sformatf("rst%0d_wr_rd", k), {30'd0, bwr[k], brd[k]}, 0);
            chk($sformatf("rst%0d_addr", k), baddr[k], 0);
            chk($sformatf("rst%0d_data_i", k), bdi[k], 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) do_txn(i, tbl[i]);
        stall_seq();
        reset_seq();
`ifdef BUS_MASTER_RD_BURST_EN
        burst_seq();
`endif
        for (int k = 0; k < 3; k++) run_random(k, 40);

        chk("strobe_exclusive", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
